// File: rtl/bp_fe_fetch_queue.sv
// Fetch queue behind the two-cycle FE memory stage: pairs responses with their
// PCs, buffers good/faulting fetches for the backend and turns misses into replays.
module bp_fe_fetch_queue #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int els_p         = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         issue_v_i,
  input  logic [vaddr_width_p-1:0]     issue_pc_i,
  output logic                         issue_ready_o,
  input  logic                         poison_i,
  input  logic                         resp_v_i,
  input  logic [instr_width_p-1:0]     resp_instr_i,
  input  logic                         resp_icache_miss_i,
  input  logic                         resp_itlb_miss_i,
  input  logic                         resp_page_fault_i,
  input  logic                         resp_access_fault_i,
  output logic                         fetch_v_o,
  output logic [vaddr_width_p-1:0]     fetch_pc_o,
  output logic [instr_width_p-1:0]     fetch_instr_o,
  output logic [1:0]                   fetch_exc_o,
  input  logic                         fetch_yumi_i,
  output logic                         replay_v_o,
  output logic [vaddr_width_p-1:0]     replay_pc_o,
  output logic                         replay_itlb_o,
  input  logic                         replay_yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  typedef enum logic {ST_RUN, ST_REPLAY} state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic                       r_v1;
  logic                       r_v2;
  logic [vaddr_width_p-1:0]   r_pc1;
  logic [vaddr_width_p-1:0]   r_pc2;
  logic [ptr_w-1:0]           r_wptr;
  logic [ptr_w-1:0]           r_rptr;
  logic [cnt_w-1:0]           r_count;
  logic [vaddr_width_p-1:0]   r_replay_pc;
  logic                       r_replay_itlb;
  logic [vaddr_width_p-1:0]   r_mem_pc    [els_p];
  logic [instr_width_p-1:0]   r_mem_instr [els_p];
  logic [1:0]                 r_mem_exc   [els_p];

  logic                       w_resp_take;
  logic                       w_fault;
  logic                       w_miss;
  logic                       w_enq;
  logic                       w_deq;
  logic                       w_replay_start;
  logic                       w_empty;
  logic                       w_full;
  logic [1:0]                 w_exc;
  logic [cnt_w:0]             w_credit_used;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_pc1 <= '0;
      r_pc2 <= '0;
    end else begin
      r_v1  <= issue_v_i & ~flush_i;
      r_pc1 <= issue_pc_i;
      r_v2  <= r_v1 & ~poison_i & ~flush_i;
      r_pc2 <= r_pc1;
    end
  end

  assign w_resp_take    = resp_v_i & r_v2 & ~flush_i & (r_state == ST_RUN);
  assign w_fault        = resp_page_fault_i | resp_access_fault_i;
  assign w_miss         = (resp_itlb_miss_i | resp_icache_miss_i) & ~w_fault;
  assign w_enq          = w_resp_take & ~w_miss;
  assign w_replay_start = w_resp_take & w_miss;
  assign w_exc          = resp_page_fault_i   ? 2'b10 :
                          resp_access_fault_i ? 2'b01 : 2'b00;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == cnt_w'(els_p));
  assign w_deq   = fetch_yumi_i & ~w_empty & ~flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + cnt_w'(w_enq) - cnt_w'(w_deq);
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked
  // entirely by the pointers and count, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem_pc[r_wptr]    <= r_pc2;
      r_mem_instr[r_wptr] <= resp_instr_i;
      r_mem_exc[r_wptr]   <= w_exc;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_replay_pc   <= '0;
      r_replay_itlb <= 1'b0;
    end else if (w_replay_start) begin
      r_replay_pc   <= r_pc2;
      r_replay_itlb <= resp_itlb_miss_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_RUN;
    else            r_state <= w_state_next;
  end

  // NOTE: next state is given a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_replay_start) w_state_next = ST_REPLAY;
      ST_REPLAY: if (replay_yumi_i)  w_state_next = ST_RUN;
      default:                       w_state_next = ST_RUN;
    endcase
    if (flush_i) w_state_next = ST_RUN;
  end

  // Everything in flight has a slot reserved, so a response can never overflow.
  assign w_credit_used = {1'b0, r_count} + (cnt_w+1)'(r_v1) + (cnt_w+1)'(r_v2);
  assign issue_ready_o = reset_n_i & (r_state == ST_RUN) & ~flush_i
                       & (w_credit_used < (cnt_w+1)'(els_p));

  assign fetch_v_o     = ~w_empty;
  assign fetch_pc_o    = w_empty ? '0    : r_mem_pc[r_rptr];
  assign fetch_instr_o = w_empty ? '0    : r_mem_instr[r_rptr];
  assign fetch_exc_o   = w_empty ? 2'b00 : r_mem_exc[r_rptr];
  assign count_o       = r_count;

  assign replay_v_o    = (r_state == ST_REPLAY);
  assign replay_pc_o   = replay_v_o ? r_replay_pc : '0;
  assign replay_itlb_o = replay_v_o & r_replay_itlb;

  a_resp_has_fetch: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(resp_v_i && !r_v2));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(w_enq && w_full && !w_deq));

endmodule
